// File: rtl/tt_um_practice_verilog.sv
// tt_um_practice_verilog: 8-bit accumulator ALU on a Tiny Tapeout tile.
// A rising edge of uio_in[4] executes opcode uio_in[3:0] with operand ui_in
// against the accumulator. The accumulator drives uo_out; Z/C/V drive uio_out[7:5].
module tt_um_practice_verilog (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LOAD = 4'h1, OP_ADD  = 4'h2, OP_SUB  = 4'h3,
        OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR  = 4'h6, OP_NOT  = 4'h7,
        OP_SHL  = 4'h8, OP_SHR  = 4'h9, OP_ROL  = 4'hA, OP_ROR  = 4'hB,
        OP_INC  = 4'hC, OP_DEC  = 4'hD, OP_CLR  = 4'hE, OP_SWAP = 4'hF
    } op_e;

    typedef struct packed {
        logic [7:0] acc;
        logic       z;
        logic       c;
        logic       v;
    } alu_st_t;

    alu_st_t    st_q;
    alu_st_t    st_d;
    logic       hist_q;
    logic       fire;
    op_e        op;
    logic [7:0] a;
    logic [8:0] sum9;
    logic [8:0] dif9;

    // uio_in[7:5] carry no function on this tile
    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in[7:5]};

    assign op   = op_e'(uio_in[3:0]);
    assign a    = ui_in;
    assign fire = ena & uio_in[4] & ~hist_q;
    assign sum9 = {1'b0, st_q.acc} + {1'b0, a};
    assign dif9 = {1'b0, st_q.acc} - {1'b0, a};

    // Next accumulator/flags for the current opcode; Z is derived from the result
    always_comb begin
        st_d   = st_q;
        st_d.c = 1'b0;
        st_d.v = 1'b0;
        unique case (op)
            OP_LOAD: st_d.acc = a;
            OP_ADD: begin
                st_d.acc = sum9[7:0];
                st_d.c   = sum9[8];
                st_d.v   = (st_q.acc[7] == a[7]) && (sum9[7] != st_q.acc[7]);
            end
            OP_SUB: begin
                st_d.acc = dif9[7:0];
                st_d.c   = dif9[8];
                st_d.v   = (st_q.acc[7] != a[7]) && (dif9[7] != st_q.acc[7]);
            end
            OP_AND:  st_d.acc = st_q.acc & a;
            OP_OR:   st_d.acc = st_q.acc | a;
            OP_XOR:  st_d.acc = st_q.acc ^ a;
            OP_NOT:  st_d.acc = ~st_q.acc;
            OP_SHL: begin
                st_d.acc = {st_q.acc[6:0], 1'b0};
                st_d.c   = st_q.acc[7];
            end
            OP_SHR: begin
                st_d.acc = {1'b0, st_q.acc[7:1]};
                st_d.c   = st_q.acc[0];
            end
            OP_ROL: begin
                st_d.acc = {st_q.acc[6:0], st_q.acc[7]};
                st_d.c   = st_q.acc[7];
            end
            OP_ROR: begin
                st_d.acc = {st_q.acc[0], st_q.acc[7:1]};
                st_d.c   = st_q.acc[0];
            end
            OP_INC: begin
                st_d.acc = st_q.acc + 8'd1;
                st_d.c   = (st_q.acc == 8'hFF);
                st_d.v   = (st_q.acc == 8'h7F);
            end
            OP_DEC: begin
                st_d.acc = st_q.acc - 8'd1;
                st_d.c   = (st_q.acc == 8'h00);
                st_d.v   = (st_q.acc == 8'h80);
            end
            OP_CLR:  st_d.acc = 8'h00;
            OP_SWAP: st_d.acc = {st_q.acc[3:0], st_q.acc[7:4]};
            default: begin
                // NOP keeps everything, flags included
                st_d.c = st_q.c;
                st_d.v = st_q.v;
            end
        endcase
        if (op != OP_NOP)
            st_d.z = (st_d.acc == 8'h00);
    end

    // History starts at 1 so a strobe held through reset must drop before it can fire
    always_ff @(posedge clk) begin
        if (!rst_n)
            hist_q <= 1'b1;
        else
            hist_q <= uio_in[4];
    end

    // Accumulator and flags change only on an executing edge
    always_ff @(posedge clk) begin
        if (!rst_n)
            st_q <= '0;
        else if (fire)
            st_q <= st_d;
    end

    assign uo_out  = st_q.acc;
    assign uio_out = {st_q.z, st_q.c, st_q.v, 5'b00000};
    assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_practice_verilog.sv
// Directed bench for tt_um_practice_verilog: hand-computed expectations per step.
module tb_tt_um_practice_verilog;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests = 0;
    int fails = 0;

    tt_um_practice_verilog dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Strobe one opcode: raise at a negedge, drop at the next; the posedge between executes
    task automatic exec(input logic [3:0] op, input logic [7:0] a);
        @(negedge clk);
        ui_in  = a;
        uio_in = {3'b000, 1'b1, op};
        @(negedge clk);
        uio_in[4] = 1'b0;
    endtask

    task automatic chk2(input string tag, input logic [7:0] acc, input logic [7:0] fl);
        check({tag, "_acc"}, uo_out, acc);
        check({tag, "_flg"}, uio_out, fl);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk2("reset", 8'h00, 8'h00);
        check("uio_oe", uio_oe, 8'hE0);

        exec(4'h1, 8'h7F);
        exec(4'h2, 8'h01);
        chk2("add_ovf", 8'h80, 8'h20);

        exec(4'h1, 8'h05);
        exec(4'h3, 8'h06);
        chk2("sub_borrow", 8'hFF, 8'h40);
        exec(4'hC, 8'h00);
        chk2("inc_wrap", 8'h00, 8'hC0);

        exec(4'h1, 8'h81);
        chk2("load81", 8'h81, 8'h00);
        exec(4'h8, 8'h00);
        chk2("shl", 8'h02, 8'h40);
        exec(4'hA, 8'h00);
        chk2("rol", 8'h04, 8'h00);
        exec(4'hF, 8'h00);
        chk2("swap", 8'h40, 8'h00);

        exec(4'h1, 8'hF0);
        exec(4'h4, 8'h3C);
        chk2("and", 8'h30, 8'h00);
        exec(4'h5, 8'h0F);
        chk2("or", 8'h3F, 8'h00);
        exec(4'h6, 8'hFF);
        chk2("xor", 8'hC0, 8'h00);
        exec(4'h7, 8'h00);
        chk2("not", 8'h3F, 8'h00);
        exec(4'h9, 8'h00);
        chk2("shr", 8'h1F, 8'h40);
        exec(4'hB, 8'h00);
        chk2("ror", 8'h8F, 8'h40);
        exec(4'hD, 8'h00);
        chk2("dec", 8'h8E, 8'h00);
        exec(4'hE, 8'h00);
        chk2("clr", 8'h00, 8'h80);
        exec(4'hD, 8'h00);
        chk2("dec_wrap", 8'hFF, 8'h40);
        exec(4'h1, 8'h80);
        exec(4'hD, 8'h00);
        chk2("dec_ovf", 8'h7F, 8'h20);
        exec(4'hC, 8'h00);
        chk2("inc_ovf", 8'h80, 8'h20);
        exec(4'h0, 8'h33);
        chk2("nop", 8'h80, 8'h20);
        exec(4'h1, 8'hFF);
        exec(4'h2, 8'h01);
        chk2("add_carry", 8'h00, 8'hC0);
        exec(4'h1, 8'h80);
        exec(4'h3, 8'h01);
        chk2("sub_ovf", 8'h7F, 8'h20);

        // Strobe held high: single execution
        exec(4'h1, 8'h10);
        @(negedge clk);
        uio_in = {3'b000, 1'b1, 4'hC};
        repeat (5) @(negedge clk);
        uio_in[4] = 1'b0;
        @(negedge clk);
        chk2("hold_once", 8'h11, 8'h00);

        // Strobe with ena low is lost, not deferred
        ena = 1'b0;
        exec(4'hC, 8'h00);
        ena = 1'b1;
        repeat (2) @(negedge clk);
        chk2("ena_off", 8'h11, 8'h00);

        // Operand/opcode changes without a strobe do nothing
        uio_in = {3'b000, 1'b0, 4'h1};
        ui_in  = 8'hAA;
        repeat (3) @(negedge clk);
        chk2("no_strobe", 8'h11, 8'h00);

        // Strobe held across reset must drop before it can fire again
        @(negedge clk);
        uio_in = {3'b000, 1'b1, 4'h0};
        @(negedge clk);
        rst_n = 1'b0;
        uio_in = {3'b000, 1'b1, 4'h1};
        ui_in  = 8'h55;
        repeat (2) @(negedge clk);
        chk2("rst_hold", 8'h00, 8'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk2("post_rst", 8'h00, 8'h00);
        uio_in[4] = 1'b0;
        @(negedge clk);
        exec(4'h1, 8'h55);
        chk2("rearm", 8'h55, 8'h00);
        check("uio_oe_end", uio_oe, 8'hE0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
